// File: rtl/ym_detune_pkg.sv
// ----------------------------------------------------------------------------
// ym_detune_pkg
// Shared definitions for the multi-slot detune / phase-increment unit:
// default widths, detune exponent bounds, the detune mantissa table and the
// per-slot control record carried through the pipeline.
// No ports (package).
// ----------------------------------------------------------------------------
package ym_detune_pkg;

    // Default configuration of ym_detune_pinc_mc.
    localparam int SLOTS_DEF   = 24;
    localparam int FNUM_W_DEF  = 11;
    localparam int BLOCK_W_DEF = 3;
    localparam int BASE_W_DEF  = 17;
    localparam int PINC_W_DEF  = 20;

    // Fixed-width operator fields.
    localparam int DT_W  = 3;
    localparam int KC_W  = 5;
    localparam int MUL_W = 4;
    localparam int DV_W  = 5;

    // Only exponents in [EXP_LO, EXP_HI] produce a non-zero detune.
    localparam int EXP_LO = 5;
    localparam int EXP_HI = 9;

    // Detune mantissa table, indexed by the 3 low bits of the scaled key code.
    function automatic logic [3:0] detune_mant(input logic [2:0] idx);
        logic [3:0] m;
        case (idx)
            3'd0:    m = 4'd0;
            3'd1:    m = 4'd1;
            3'd2:    m = 4'd3;
            3'd3:    m = 4'd4;
            3'd4:    m = 4'd6;
            3'd5:    m = 4'd8;
            3'd6:    m = 4'd11;
            default: m = 4'd13;
        endcase
        return m;
    endfunction

    // Stage record at the default widths. The top module rebuilds the same
    // layout locally from its own parameters so non-default configurations
    // keep exact widths.
    typedef struct packed {
        logic [DT_W-1:0]        dt;
        logic [KC_W-1:0]        kcode;
        logic [FNUM_W_DEF-1:0]  fnum;
        logic [BLOCK_W_DEF-1:0] block;
        logic [MUL_W-1:0]       mul;
        logic [$clog2(SLOTS_DEF)-1:0] slot;
    } stage_rec_t;

endpackage

// File: rtl/ym_detune_value.sv
// ----------------------------------------------------------------------------
// ym_detune_value
// Combinational detune magnitude from the DT code and the key code.
// Ports:
//   dt    [2:0] in  detune code; bit2 = sign, bits1:0 = magnitude code
//   kcode [4:0] in  key code
//   dv    [4:0] out detune magnitude
//   sub         out 1 = subtract dv from the base increment
// ----------------------------------------------------------------------------
module ym_detune_value
    import ym_detune_pkg::*;
(
    input  logic [DT_W-1:0] dt,
    input  logic [KC_W-1:0] kcode,
    output logic [DV_W-1:0] dv,
    output logic            sub
);

    logic [3:0] d;
    logic [4:0] h;
    logic [1:0] lo;
    logic [6:0] s;
    logic [3:0] e;
    logic [2:0] i;
    logic [4:0] mant_full;

    always_comb begin
        d  = {dt[1] | dt[0], 1'b0, dt[1], dt[1] & dt[0]};
        h  = 5'd1 + {1'b0, d} + {2'b00, kcode[4:2]};
        // Top key-code octave drops the fine bits.
        lo = (kcode[4:2] == 3'd7) ? 2'd0 : kcode[1:0];
        s  = {h, lo};
        e  = s[6:3];
        i  = s[2:0];
        mant_full = 5'd16 + {1'b0, detune_mant(i)};

        dv = '0;
        if (dt[1:0] != 2'd0 && e >= 4'(EXP_LO) && e <= 4'(EXP_HI))
            dv = mant_full >> (4'(EXP_HI) - e);

        sub = dt[2];
    end

endmodule

// File: rtl/ym_detune_pinc_mc.sv
// ----------------------------------------------------------------------------
// ym_detune_pinc_mc
// Time-multiplexed phase-increment unit. Each step (a c1 edge followed by a
// c2 edge) accepts one operator slot; three master/slave stages produce the
// detuned, multiplied phase increment 3 steps later, tagged with its slot.
// There is no backpressure: a step always advances every stage.
//
// Build option YM_DETUNE_WRAP_EN: when defined, base-dv underflow wraps
// modulo 2^BASE_W (silicon behaviour); when undefined it clamps to 0.
//
// Ports:
//   MCLK, reset_n          master clock, asynchronous active-low reset
//   c1, c2                 phase enables: c1 loads masters, c2 loads slaves
//   sync                   current input is slot 0
//   dt, kcode, fnum,
//   block, mul             operator parameters of the current slot
//   pinc     [PINC_W-1:0]  phase increment
//   slot_out [SLOT_W-1:0]  slot tag of pinc
//   pinc_valid             pipeline has filled since reset
// ----------------------------------------------------------------------------
module ym_detune_pinc_mc
    import ym_detune_pkg::*;
#(
    parameter int SLOTS   = SLOTS_DEF,
    parameter int FNUM_W  = FNUM_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int BASE_W  = BASE_W_DEF,
    parameter int PINC_W  = PINC_W_DEF,
    localparam int SLOT_W = $clog2(SLOTS)
)(
    input  logic               MCLK,
    input  logic               reset_n,
    input  logic               c1,
    input  logic               c2,
    input  logic               sync,
    input  logic [DT_W-1:0]    dt,
    input  logic [KC_W-1:0]    kcode,
    input  logic [FNUM_W-1:0]  fnum,
    input  logic [BLOCK_W-1:0] block,
    input  logic [MUL_W-1:0]   mul,
    output logic [PINC_W-1:0]  pinc,
    output logic [SLOT_W-1:0]  slot_out,
    output logic               pinc_valid
);

    // Widest fnum << block before the final halving.
    localparam int SH_W   = FNUM_W + (1 << BLOCK_W) - 1;
    localparam int PROD_W = BASE_W + MUL_W;

    typedef struct packed {
        logic [DT_W-1:0]    dt;
        logic [KC_W-1:0]    kcode;
        logic [FNUM_W-1:0]  fnum;
        logic [BLOCK_W-1:0] block;
        logic [MUL_W-1:0]   mul;
        logic [SLOT_W-1:0]  slot;
    } rec_t;

    // Stage 1: registered inputs.
    rec_t s1_m, s1_s;
    logic s1_v_m, s1_v_s;

    // Stage 2: base increment and detune magnitude.
    logic [BASE_W-1:0] s2_base_m, s2_base_s;
    logic [DV_W-1:0]   s2_dv_m, s2_dv_s;
    logic              s2_sub_m, s2_sub_s;
    logic [MUL_W-1:0]  s2_mul_m, s2_mul_s;
    logic [SLOT_W-1:0] s2_slot_m, s2_slot_s;
    logic              s2_v_m, s2_v_s;

    // Stage 3: final increment (slave side is the output ports).
    logic [PINC_W-1:0] s3_pinc_m;
    logic [SLOT_W-1:0] s3_slot_m;
    logic              s3_v_m;

    // The stage-1 slot tag doubles as the slot counter.
    logic [SLOT_W-1:0] slot_next;
    always_comb begin
        slot_next = s1_s.slot + 1'b1;
        if (sync || s1_s.slot == SLOT_W'(SLOTS - 1))
            slot_next = '0;
    end

    logic [SH_W-1:0]   base_wide;
    logic [BASE_W-1:0] base_val;
    logic [DV_W-1:0]   dv_val;
    logic              sub_val;

    always_comb begin
        base_wide = SH_W'(s1_s.fnum) << s1_s.block;
        base_val  = BASE_W'(base_wide >> 1);
    end

    ym_detune_value u_detune_value (
        .dt    (s1_s.dt),
        .kcode (s1_s.kcode),
        .dv    (dv_val),
        .sub   (sub_val)
    );

    logic [BASE_W-1:0] dv_ext;
    logic [BASE_W-1:0] t_val;
    logic [PROD_W-1:0] prod;
    logic [PINC_W-1:0] p_val;

    always_comb begin
        dv_ext = BASE_W'(s2_dv_s);
        if (s2_sub_s) begin
`ifdef YM_DETUNE_WRAP_EN
            t_val = s2_base_s - dv_ext;
`else
            t_val = (dv_ext > s2_base_s) ? '0 : s2_base_s - dv_ext;
`endif
        end else begin
            t_val = s2_base_s + dv_ext;
        end
        prod  = PROD_W'(t_val) * PROD_W'(s2_mul_s);
        // mul == 0 selects the x0.5 multiplier.
        p_val = (s2_mul_s == '0) ? PINC_W'(t_val >> 1) : PINC_W'(prod);
    end

    // Master latches: load on c1.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            s1_m      <= '0;
            s1_v_m    <= 1'b0;
            s2_base_m <= '0;
            s2_dv_m   <= '0;
            s2_sub_m  <= 1'b0;
            s2_mul_m  <= '0;
            s2_slot_m <= '0;
            s2_v_m    <= 1'b0;
            s3_pinc_m <= '0;
            s3_slot_m <= '0;
            s3_v_m    <= 1'b0;
        end else if (c1) begin
            s1_m.dt    <= dt;
            s1_m.kcode <= kcode;
            s1_m.fnum  <= fnum;
            s1_m.block <= block;
            s1_m.mul   <= mul;
            s1_m.slot  <= slot_next;
            s1_v_m     <= 1'b1;
            s2_base_m  <= base_val;
            s2_dv_m    <= dv_val;
            s2_sub_m   <= sub_val;
            s2_mul_m   <= s1_s.mul;
            s2_slot_m  <= s1_s.slot;
            s2_v_m     <= s1_v_s;
            s3_pinc_m  <= p_val;
            s3_slot_m  <= s2_slot_s;
            s3_v_m     <= s2_v_s;
        end
    end

    // Slave registers: load on c2.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            s1_s       <= '0;
            s1_v_s     <= 1'b0;
            s2_base_s  <= '0;
            s2_dv_s    <= '0;
            s2_sub_s   <= 1'b0;
            s2_mul_s   <= '0;
            s2_slot_s  <= '0;
            s2_v_s     <= 1'b0;
            pinc       <= '0;
            slot_out   <= '0;
            pinc_valid <= 1'b0;
        end else if (c2) begin
            s1_s       <= s1_m;
            s1_v_s     <= s1_v_m;
            s2_base_s  <= s2_base_m;
            s2_dv_s    <= s2_dv_m;
            s2_sub_s   <= s2_sub_m;
            s2_mul_s   <= s2_mul_m;
            s2_slot_s  <= s2_slot_m;
            s2_v_s     <= s2_v_m;
            pinc       <= s3_pinc_m;
            slot_out   <= s3_slot_m;
            pinc_valid <= s3_v_m;
        end
    end

endmodule

// File: tb/tb_ym_detune_pinc_mc.sv
// ----------------------------------------------------------------------------
// tb_ym_detune_pinc_mc
// Directed bench for ym_detune_pinc_mc. Each step pushes its hand-computed
// pinc and the expected slot tag into queues; once three steps are in flight
// the oldest entry is compared against the outputs.
// ----------------------------------------------------------------------------
module tb_ym_detune_pinc_mc;

    localparam int W = 20;

    logic        MCLK;
    logic        reset_n;
    logic        c1;
    logic        c2;
    logic        sync;
    logic [2:0]  dt;
    logic [4:0]  kcode;
    logic [10:0] fnum;
    logic [2:0]  block;
    logic [3:0]  mul;
    logic [19:0] pinc;
    logic [4:0]  slot_out;
    logic        pinc_valid;

    int total = 0;
    int bad   = 0;
    int slot_model = 0;

    logic [W-1:0] exp_q[$];
    logic [4:0]   exp_slot_q[$];

    ym_detune_pinc_mc dut (
        .MCLK       (MCLK),
        .reset_n    (reset_n),
        .c1         (c1),
        .c2         (c2),
        .sync       (sync),
        .dt         (dt),
        .kcode      (kcode),
        .fnum       (fnum),
        .block      (block),
        .mul        (mul),
        .pinc       (pinc),
        .slot_out   (slot_out),
        .pinc_valid (pinc_valid)
    );

    // ---------------- clock ----------------
    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // c1 and c2 must never overlap.
    always @(posedge MCLK) begin
        assert (!(c1 && c2)) else $error("c1 and c2 high together");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One step: c1 edge, optional idle MCLKs, then c2 edge. Outputs are
    // sampled on the falling edge afterwards.
    task automatic do_step(input logic sy, input logic [2:0] d, input logic [4:0] k,
                           input logic [10:0] f, input logic [2:0] b, input logic [3:0] m,
                           input int gap, input logic [W-1:0] exp_p);
        logic [W-1:0] ep;
        logic [4:0]   es;
        @(negedge MCLK);
        sync = sy; dt = d; kcode = k; fnum = f; block = b; mul = m;
        c1 = 1'b1; c2 = 1'b0;
        @(negedge MCLK);
        c1 = 1'b0;
        repeat (gap) @(negedge MCLK);
        c2 = 1'b1;
        @(negedge MCLK);
        c2 = 1'b0;
        slot_model = sy ? 0 : ((slot_model == 23) ? 0 : slot_model + 1);
        exp_q.push_back(exp_p);
        exp_slot_q.push_back(5'(slot_model));
        if (exp_q.size() == 3) begin
            ep = exp_q.pop_front();
            es = exp_slot_q.pop_front();
            check("pinc", 32'(pinc), 32'(ep));
            check("slot_out", 32'(slot_out), 32'(es));
            check("pinc_valid", 32'(pinc_valid), 32'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] exp_wrap;

    initial begin
        reset_n = 1'b0;
        c1 = 1'b0; c2 = 1'b0; sync = 1'b0;
        dt = '0; kcode = '0; fnum = '0; block = '0; mul = '0;
`ifdef YM_DETUNE_WRAP_EN
        exp_wrap = 20'd131050;
`else
        exp_wrap = 20'd0;
`endif
        repeat (3) @(negedge MCLK);
        check("rst_pinc", 32'(pinc), 32'd0);
        check("rst_slot", 32'(slot_out), 32'd0);
        check("rst_valid", 32'(pinc_valid), 32'd0);
        reset_n = 1'b1;

        // Directed vectors: sy dt kc fnum block mul gap expected
        do_step(1'b1, 3'd0, 5'd0,  11'h400, 3'd4, 4'd1,  0, 20'd8192);
        do_step(1'b0, 3'd1, 5'd31, 11'h400, 3'd4, 4'd1,  0, 20'd8200);
        check("valid_fill", 32'(pinc_valid), 32'd0);
        do_step(1'b0, 3'd1, 5'd31, 11'h400, 3'd4, 4'd0,  0, 20'd4100);
        do_step(1'b0, 3'd1, 5'd31, 11'h400, 3'd4, 4'd15, 0, 20'd123000);
        do_step(1'b0, 3'd3, 5'd31, 11'h400, 3'd4, 4'd1,  0, 20'd8214);
        do_step(1'b0, 3'd5, 5'd31, 11'h400, 3'd4, 4'd1,  0, 20'd8184);
        do_step(1'b0, 3'd7, 5'd31, 11'h000, 3'd0, 4'd1,  0, exp_wrap);
        do_step(1'b0, 3'd2, 5'd10, 11'h400, 3'd4, 4'd2,  0, 20'd16390);
        do_step(1'b0, 3'd1, 5'd0,  11'h400, 3'd4, 4'd1,  5, 20'd8192);
        do_step(1'b0, 3'd0, 5'd0,  11'h7ff, 3'd7, 4'd1,  0, 20'd131008);
        do_step(1'b0, 3'd3, 5'd31, 11'h7ff, 3'd7, 4'd1,  5, 20'd131030);
        do_step(1'b0, 3'd2, 5'd10, 11'h400, 3'd4, 4'd0,  0, 20'd4097);

        // Free-running slots with a realigning sync where slot 10 would be.
        for (int i = 0; i < 40; i++)
            do_step((i == 0) || (i == 34), 3'd0, 5'd0, 11'h400, 3'd4, 4'd1, 0, 20'd8192);

        // Reset between c1 and c2 while data is in flight.
        @(negedge MCLK);
        dt = 3'd1; kcode = 5'd31; c1 = 1'b1;
        @(negedge MCLK);
        c1 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_pinc", 32'(pinc), 32'd0);
        check("mid_rst_slot", 32'(slot_out), 32'd0);
        check("mid_rst_valid", 32'(pinc_valid), 32'd0);
        @(negedge MCLK);
        reset_n = 1'b1;
        exp_q.delete();
        exp_slot_q.delete();
        slot_model = 0;

        do_step(1'b1, 3'd3, 5'd31, 11'h400, 3'd4, 4'd1, 0, 20'd8214);
        check("post_rst_valid1", 32'(pinc_valid), 32'd0);
        do_step(1'b0, 3'd0, 5'd0,  11'h400, 3'd4, 4'd1, 0, 20'd8192);
        check("post_rst_valid2", 32'(pinc_valid), 32'd0);
        do_step(1'b0, 3'd5, 5'd31, 11'h400, 3'd4, 4'd1, 0, 20'd8184);
        do_step(1'b0, 3'd0, 5'd0,  11'h400, 3'd4, 4'd1, 0, 20'd8192);
        do_step(1'b0, 3'd0, 5'd0,  11'h400, 3'd4, 4'd1, 0, 20'd8192);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ym_detune_pinc_mc.md
Name: ym_detune_pinc_mc

Overview:
- Multi-slot, time-multiplexed phase-increment unit for the FM operator pipeline.
- Per slot, computes the detune magnitude from DT and key code, and adds or subtracts it from the block-shifted F-number.
- Applies the frequency multiplier and emits the final phase increment to the phase generator.
- Generalises the single-slot detune lookup: configurable slot count and widths, slot tracking, and a 3-step pipeline.

Parameters:
SLOTS, 24, number of time-multiplexed operator slots; slot counter wraps at SLOTS-1
FNUM_W, 11, F-number width
BLOCK_W, 3, octave/block width
BASE_W, 17, width of the detuned base increment; arithmetic is modulo 2^BASE_W
PINC_W, 20, output phase-increment width; the multiplier result is truncated to this width
LAT, 3, pipeline depth in steps; fixed, not user-tunable

Ports:
MCLK  in  1  master clock
reset_n  in  1  asynchronous active-low reset
c1  in  1  phase-1 enable; inputs sampled into master latches
c2  in  1  phase-2 enable; master latches transfer to stage outputs (one "step" = c1 edge followed by c2 edge)
sync  in  1  marks the input as slot 0
dt  in  3  detune: bit2 = sign (1 = subtract), bits1:0 = magnitude code
kcode  in  5  key code
fnum  in  FNUM_W  F-number
block  in  BLOCK_W  block
mul  in  4  multiplier; 0 means x0.5
pinc  out  PINC_W  phase increment for the slot in slot_out
slot_out  out  $clog2(SLOTS)  slot tag of pinc
pinc_valid  out  1  pipeline filled since reset

Behaviour:
- Reset is asynchronous and active-low. On assertion, all master and slave registers clear immediately: pinc=0, slot_out=0, pinc_valid=0, slot counter=0.
- Reset asserted mid-operation discards in-flight data. After release, pinc_valid rises on the c2 edge completing the 3rd step.
- Register update rules:
  - Master latch loads only on MCLK rising edges with c1=1.
  - Slave loads only on edges with c2=1.
  - With c1=c2=0 everything holds.
  - c1 and c2 both high is illegal; the bench flags it with an assertion.
- Slot counter:
  - On a step, cnt <= sync ? 0 : (cnt==SLOTS-1 ? 0 : cnt+1).
  - The counter tags stage 1. The tag travels with the data, so slot_out = input slot delayed 3 steps.
  - A sync pulse arriving mid-sequence re-aligns immediately, with no error.
- Stage 1: register dt, kcode, fnum, block, mul, and the slot tag.
- Stage 2, detune magnitude dv (5 bits):
  - If dt[1:0]==0, dv=0.
  - Otherwise, let d = {dt1|dt0, 0, dt1, dt1&dt0}. Compute h = 1 + d + kcode[4:2] (5 bits).
  - Low bits lo = (kcode[4:2]==7) ? 0 : kcode[1:0]. Form s = {h, lo} (7 bits).
  - Let e = s[6:3] and i = s[2:0]. Mantissa M[i] = {0,1,3,4,6,8,11,13}[i].
  - dv = (16+M[i]) >> (9-e) when 5<=e<=9; dv=0 otherwise.
- Stage 2, base increment: base = (fnum << block) >> 1, zero-extended to BASE_W.
- Stage 3, detune application: t = dt[2] ? base - dv : base + dv, computed modulo 2^BASE_W. Negative handling is set by the optional feature below.
- Stage 3, multiply: p = (mul==0) ? t>>1 : t*mul, truncated to PINC_W, registered to pinc.
- Latency: exactly 3 steps from the input step to pinc/slot_out.

Optional Feature:
- Macro: YM_DETUNE_WRAP_EN.
- Defined: an underflow of base-dv wraps modulo 2^BASE_W, matching the silicon.
- Undefined: an underflow clamps t to 0.
- Overflow of base+dv always wraps, in both builds.

Decomposition:
- Package ym_detune_pkg holds:
  - the mantissa table M
  - the exponent bounds 5 and 9
  - default widths
  - a stage record typedef: dt, kcode, fnum, block, mul, slot
- Sub-module ym_detune_value: combinational dt/kcode -> dv, sign. It is instantiated once in stage 2.

Test Plan:
- dt=0, fnum=0x400, block=4, mul=1: pinc=8192 exactly 3 steps later.
- dt=1, kcode=31, same fnum/block/mul: dv=8 -> pinc=8200. With mul=0: pinc=4100. With mul=15: pinc=123000.
- dt=3, kcode=31: dv=22 -> pinc=8214. dt=5, kcode=31: dv=8, subtract -> pinc=8184.
- fnum=0, block=0, dt=7, kcode=31, mul=1: pinc=131050 with YM_DETUNE_WRAP_EN defined; pinc=0 without it.
- sync pulse, then 30 steps of free-running input: slot_out runs 0..23, 0..5 (offset by 3 steps). A sync injected at count 10 restarts tagging at 0.
- Assert reset_n low between c1 and c2 mid-stream: outputs go to 0 immediately. pinc_valid returns 3 full steps after release. A c1/c2 gap of 5 idle MCLKs changes nothing.
